anita3_trigger_arbiter: RTL
===========================

# anita3_trigger_arbiter

Trigger-source arbiter in the clk250 domain that sits between the four trigger sources (RF, PPS1, PPS2, software) and the buffer manager. It edge-detects and latches requests, grants one source at a time in fixed priority, enforces a programmable minimum spacing between grants, and stalls while the buffer manager reports dead. Requests that arrive while the same source is already pending are counted as drops.

## Interface
- NUM_SRC, 4, number of trigger sources; index 0 has the highest priority (0=RF, 1=PPS1, 2=PPS2, 3=SOFT).
- HOLDOFF_W, 8, width of the holdoff setting.
- DROP_W, 16, width of each drop counter.

Ports:
- clk250_i  in  1  single clock (250 MHz).
- rst_i  in  1  synchronous, active-high reset.
- trig_req_i  in  NUM_SRC  raw trigger request lines, pulse or level; rising edges are used.
- src_en_i  in  NUM_SRC  per-source enable.
- holdoff_i  in  HOLDOFF_W  extra idle cycles after each grant.
- dead_i  in  1  buffer manager cannot accept a trigger.
- drop_clr_i  in  1  clear all drop counters.
- trig_o  out  NUM_SRC  one-hot, single-cycle grant to the buffer manager.
- trig_src_o  out  2  encoded index of the most recent grant, held until the next grant.
- pending_o  out  NUM_SRC  latched, not-yet-granted requests.
- busy_o  out  1  high in GRANT or HOLDOFF.
- drop_count_o  out  NUM_SRC*DROP_W  per-source drop counters; source i occupies bits [i*DROP_W +: DROP_W].

## Operation
- **Edge detect:** `req_d` is a register of trig_req_i. An edge on source i is `trig_req_i[i] & ~req_d[i] & src_en_i[i]`.
- **Pending latch:** an edge sets pending[i].
  - If pending[i] is already set and is not cleared in that cycle, the edge is a drop: drop_count[i] increments and saturates at all-ones.
  - Deasserting src_en_i[i] clears pending[i] on the next edge of clk250_i.
- **State machine: IDLE, GRANT, HOLDOFF.**
  - IDLE: if pending is non-zero and dead_i=0, select the lowest set index k.
    - Next cycle: enter GRANT, trig_o = one-hot k, trig_src_o = k.
    - pending[k] clears and holdoff_i is latched into `hcnt`.
    - If dead_i=1, remain in IDLE; pending bits are retained.
  - GRANT (exactly 1 cycle): if `hcnt`=0, go to IDLE; otherwise go to HOLDOFF.
  - HOLDOFF: decrement `hcnt` each cycle; go to IDLE when `hcnt` reaches 1 (`hcnt` cycles total). dead_i and holdoff_i changes are ignored here.
- **Simultaneity:**
  - An edge on source k in the same cycle pending[k] is cleared by a grant sets pending[k]; this is not a drop.
  - Multiple simultaneous edges all latch; they are granted in priority order on successive grant slots.
- **drop_clr_i:** zeroes all counters. If it coincides with a drop, the counter becomes 0.
- **Reset:** state IDLE, pending 0, trig_o 0, trig_src_o 0, busy_o 0, `hcnt` 0, drop counters 0.
  - `req_d` resets to all-ones, so lines held high through reset do not trigger.
  - Reset asserted mid-GRANT or mid-HOLDOFF aborts immediately; trig_o is 0 in the first cycle after reset.

## Timing
- Edge sampled at cycle n → pending set at n+1 → trig_o high at n+2 (state IDLE, dead_i=0 at n+1).
- Grant at cycle g → next earliest grant at g+holdoff+2.
- trig_o is registered and high for exactly one cycle per grant; never more than one bit set.
- dead_i is sampled only in IDLE; its effect appears one cycle later.
- busy_o is registered and equals (state != IDLE).
- pending_o and drop_count_o are registered and update one cycle after the causing edge.
- trig_src_o changes in the same cycle trig_o asserts.

## Configuration
- Macro: `TRIG_ARB_DROP_COUNT_EN`.
  - Defined: drop counters are implemented as described.
  - Undefined: counters and their logic are omitted; drop_count_o is tied to 0 and drop_clr_i is ignored. Grant behaviour is identical in both cases.

## Test plan
- Single RF pulse at cycle 10 (holdoff_i=0, all enabled, dead_i=0) → trig_o=4'b0001 at cycle 12 only; trig_src_o=0; busy_o high at cycle 12 only.
- Pulses on sources 3, 1 and 0 in the same cycle with holdoff_i=3 → grants 0001, 0010, 1000 at 5-cycle spacing; pending_o goes 1011 → 1010 → 1000 → 0000.
- dead_i held high for 20 cycles with PPS2 pending → no trig_o during that time; trig_o=0100 one cycle after dead_i falls (IDLE sampling).
- Three SOFT pulses 2 cycles apart while dead_i=1 → one grant after dead_i drops; drop_count_o[3*16 +: 16]=2; drop_clr_i → 0. With the macro undefined, the count is always 0.
- src_en_i[0]=0 with RF pulses → no pending and no grant. Source 1 enabled and held high through reset release → no grant until the line falls and rises again.
- Reset asserted in HOLDOFF with holdoff_i=200 and pending=0100 → all outputs 0 the cycle after; no grant until a new request arrives.

Source files
------------

// File: rtl/anita3_trigger_arbiter_if.sv
// Bus bundle between the trigger arbiter and its surroundings.
// master: trigger sources / buffer manager side; slave: the arbiter.
interface anita3_trigger_arbiter_if #(
  parameter int NUM_SRC   = 4,
  parameter int HOLDOFF_W = 8,
  parameter int DROP_W    = 16
);
  logic [NUM_SRC-1:0]        trig_req_i;
  logic [NUM_SRC-1:0]        src_en_i;
  logic [HOLDOFF_W-1:0]      holdoff_i;
  logic                      dead_i;
  logic                      drop_clr_i;
  logic [NUM_SRC-1:0]        trig_o;
  logic [1:0]                trig_src_o;
  logic [NUM_SRC-1:0]        pending_o;
  logic                      busy_o;
  logic [NUM_SRC*DROP_W-1:0] drop_count_o;

  modport master (
    output trig_req_i, src_en_i, holdoff_i, dead_i, drop_clr_i,
    input  trig_o, trig_src_o, pending_o, busy_o, drop_count_o
  );

  modport slave (
    input  trig_req_i, src_en_i, holdoff_i, dead_i, drop_clr_i,
    output trig_o, trig_src_o, pending_o, busy_o, drop_count_o
  );
endinterface

// File: rtl/anita3_trigger_arbiter.sv
// Fixed-priority trigger arbiter (clk250 domain). Rising edges on enabled
// sources latch into pending; one source is granted per slot with a
// programmable holdoff, stalling while the buffer manager reports dead.
// Optional feature macro: TRIG_ARB_DROP_COUNT_EN (per-source drop counters).
//
// state   | meaning
// IDLE    | waiting for a pending request with dead_i low
// GRANT   | single-cycle grant pulse on trig_o
// HOLDOFF | counting down hcnt idle cycles before the next grant
module anita3_trigger_arbiter #(
  parameter int NUM_SRC   = 4,
  parameter int HOLDOFF_W = 8,
  parameter int DROP_W    = 16
) (
  input logic clk250_i,
  input logic rst_i,
  anita3_trigger_arbiter_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  logic [NUM_SRC-1:0]   r_req_d;
  logic [NUM_SRC-1:0]   r_pending;
  logic [NUM_SRC-1:0]   r_trig;
  logic [1:0]           r_state;
  logic [1:0]           r_src;
  logic [HOLDOFF_W-1:0] r_hcnt;

  logic [NUM_SRC-1:0]   w_edge;
  logic [NUM_SRC-1:0]   w_grant_clr;
  logic [NUM_SRC-1:0]   w_drop;
  logic [1:0]           w_sel_idx;
  logic                 w_grant;

  // Qualified rising edges, grant decision and drop detection
  always_comb begin
    w_edge      = bus.trig_req_i & ~r_req_d & bus.src_en_i;
    w_grant     = (r_state == ST_IDLE) && (|r_pending) && !bus.dead_i;
    w_grant_clr = w_grant ? (NUM_SRC'(1) << w_sel_idx) : '0;
    // an edge on a source whose pending bit is being granted this cycle re-arms it instead
    w_drop      = w_edge & r_pending & ~w_grant_clr;
  end

  // Lowest set pending index wins (index 0 = highest priority)
  always_comb begin
    w_sel_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (r_pending[i]) w_sel_idx = i[1:0];
    end
  end

  // Request history; reset high so lines held through reset are not edges
  always_ff @(posedge clk250_i) begin
    if (rst_i) r_req_d <= '1;
    else       r_req_d <= bus.trig_req_i;
  end

  // Pending latch: set by edges, cleared by grant or source disable
  always_ff @(posedge clk250_i) begin
    if (rst_i) r_pending <= '0;
    else       r_pending <= (r_pending & ~w_grant_clr & bus.src_en_i) | w_edge;
  end

  // Grant state machine with holdoff countdown
  always_ff @(posedge clk250_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_trig  <= '0;
      r_src   <= '0;
      r_hcnt  <= '0;
    end else begin
      r_trig <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_state <= ST_GRANT;
            r_trig  <= w_grant_clr;
            r_src   <= w_sel_idx;
            r_hcnt  <= bus.holdoff_i;
          end
        end
        ST_GRANT: begin
          r_state <= (r_hcnt == '0) ? ST_IDLE : ST_HOLD;
        end
        ST_HOLD: begin
          if (r_hcnt <= HOLDOFF_W'(1)) begin
            r_state <= ST_IDLE;
            r_hcnt  <= '0;
          end else begin
            r_hcnt <= r_hcnt - HOLDOFF_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.trig_o     = r_trig;
  assign bus.trig_src_o = r_src;
  assign bus.pending_o  = r_pending;
  assign bus.busy_o     = (r_state != ST_IDLE);

`ifdef TRIG_ARB_DROP_COUNT_EN
  logic [DROP_W-1:0] r_drop_cnt [NUM_SRC];

  // Saturating per-source drop counters; clear wins over a coincident drop
  always_ff @(posedge clk250_i) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (rst_i || bus.drop_clr_i) r_drop_cnt[i] <= '0;
      else if (w_drop[i] && (r_drop_cnt[i] != '1)) r_drop_cnt[i] <= r_drop_cnt[i] + DROP_W'(1);
    end
  end

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_drop_pack
    assign bus.drop_count_o[g*DROP_W +: DROP_W] = r_drop_cnt[g];
  end
`else
  logic w_unused_drop;

  assign bus.drop_count_o = '0;
  assign w_unused_drop    = ^{bus.drop_clr_i, w_drop};
`endif

endmodule
